// File: rtl/eth_phy_rx_link_monitor.sv
// 10G PHY RX link monitor: qualifies link_up from block lock / high BER,
// pulses reset_req on prolonged loss of lock, keeps saturating RX stats.
//
// Ports:
//   clk, rst_n (sync, active low)
//   rx_block_lock, rx_high_ber, rx_error_count[6:0], rx_bad_block,
//   rx_sequence_error, stat_clear
//   link_up, reset_req, link_state[1:0] (0 WAIT_LOCK, 1 QUALIFY, 2 UP, 3 RECOVER)
//   stat_error_total, stat_bad_block, stat_seq_error, stat_link_down
//
// Optional feature macro: LINK_MON_STATS_EN
//   defined   -> four saturating counters with stat_clear
//   undefined -> stat_* tied to 0, stat_clear ignored
module eth_phy_rx_link_monitor #(
  parameter int LOCK_QUAL_CYCLES    = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int CNT_WIDTH           = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_block_lock,
  input  logic                 rx_high_ber,
  input  logic [6:0]           rx_error_count,
  input  logic                 rx_bad_block,
  input  logic                 rx_sequence_error,
  input  logic                 stat_clear,
  output logic                 link_up,
  output logic                 reset_req,
  output logic [1:0]           link_state,
  output logic [CNT_WIDTH-1:0] stat_error_total,
  output logic [CNT_WIDTH-1:0] stat_bad_block,
  output logic [CNT_WIDTH-1:0] stat_seq_error,
  output logic [CNT_WIDTH-1:0] stat_link_down
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    QUALIFY   = 2'd1,
    UP        = 2'd2,
    RECOVER   = 2'd3
  } state_t;

  localparam int MAX_QT =
    (LOCK_QUAL_CYCLES > LOCK_TIMEOUT_CYCLES) ?
    LOCK_QUAL_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_P =
    (MAX_QT > RESET_PULSE_CYCLES) ?
    MAX_QT : RESET_PULSE_CYCLES;
  localparam int TW = $clog2(MAX_P) + 1;

  localparam logic [TW-1:0] QUAL_LAST = TW'(LOCK_QUAL_CYCLES - 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] PULS_LAST = TW'(RESET_PULSE_CYCLES - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          good;
  logic          link_drop;

  assign good = rx_block_lock & ~rx_high_ber;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WAIT_LOCK;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer + TW'(1);
    link_drop = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        if (good) begin
          state_nxt = QUALIFY;
          timer_nxt = '0;
        end else if (timer == TOUT_LAST) begin
          state_nxt = RECOVER;
          timer_nxt = '0;
        end
      end
      QUALIFY: begin
        if (!good) begin
          state_nxt = WAIT_LOCK;
          timer_nxt = '0;
        end else if (timer == QUAL_LAST) begin
          state_nxt = UP;
          timer_nxt = '0;
        end
      end
      UP: begin
        // Timer is idle while up; hold it at zero so it never wraps.
        timer_nxt = '0;
        if (!good) begin
          state_nxt = WAIT_LOCK;
          link_drop = 1'b1;
        end
      end
      RECOVER: begin
        if (timer == PULS_LAST) begin
          state_nxt = WAIT_LOCK;
          timer_nxt = '0;
        end
      end
    endcase
  end

  // Decoded from next state so the flops track the state register exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      link_up    <= 1'b0;
      reset_req  <= 1'b0;
      link_state <= 2'd0;
    end else begin
      link_up    <= (state_nxt == UP);
      reset_req  <= (state_nxt == RECOVER);
      link_state <= state_nxt;
    end
  end

`ifdef LINK_MON_STATS_EN
  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] base,
    input logic [CNT_WIDTH-1:0] inc
  );
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  endfunction

  logic [CNT_WIDTH-1:0] err_inc;
  logic [CNT_WIDTH-1:0] bb_inc;
  logic [CNT_WIDTH-1:0] se_inc;
  logic [CNT_WIDTH-1:0] ld_inc;

  assign err_inc = {{(CNT_WIDTH-7){1'b0}}, rx_error_count};
  assign bb_inc  = CNT_WIDTH'(rx_bad_block);
  assign se_inc  = CNT_WIDTH'(rx_sequence_error);
  assign ld_inc  = CNT_WIDTH'(link_drop);

  // Clear takes effect first, then this cycle's increment lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_error_total <= '0;
      stat_bad_block   <= '0;
      stat_seq_error   <= '0;
      stat_link_down   <= '0;
    end else begin
      stat_error_total <= sat_add(stat_clear ? '0 : stat_error_total, err_inc);
      stat_bad_block   <= sat_add(stat_clear ? '0 : stat_bad_block, bb_inc);
      stat_seq_error   <= sat_add(stat_clear ? '0 : stat_seq_error, se_inc);
      stat_link_down   <= sat_add(stat_clear ? '0 : stat_link_down, ld_inc);
    end
  end
`else
  logic unused_stats;
  assign unused_stats = ^{stat_clear, rx_error_count, rx_bad_block,
                          rx_sequence_error, link_drop};

  assign stat_error_total = '0;
  assign stat_bad_block   = '0;
  assign stat_seq_error   = '0;
  assign stat_link_down   = '0;
`endif

endmodule
